permutation_arbiter: RTL and testbench

- Shares one Ascon Permutation core between N_REQ requesters, e.g. the encryption, decryption and hash controllers.
- Arbitrates round-robin, latches the winner's 320-bit state and round count, and drives the core's level-held start until done.
- Returns the permuted state to the winner with a one-cycle valid pulse.
- Sits between the AEAD/hash FSMs and the single Permutation + RoundCounter instance.

---
 rtl/ascon_arb_pkg.sv | 16 +
 rtl/permutation_arbiter_rr_pick.sv | 40 ++++
 rtl/permutation_arbiter.sv | 172 +++++++++++++++++
 tb/tb_permutation_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_arb_pkg.sv
// Shared encodings and constants for the Ascon permutation arbiter.
package ascon_arb_pkg;

    localparam int unsigned ASCON_W  = 320;
    localparam int unsigned ASCON_RW = 5;
    localparam int unsigned ROUNDS_A = 12;
    localparam int unsigned ROUNDS_B = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } arb_state_t;

endpackage

// File: rtl/permutation_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot_c,
    output logic [IW-1:0] idx_c,
    output logic          any_c
);

    logic          hi_found;
    logic          lo_found;
    logic [IW-1:0] hi_idx;
    logic [IW-1:0] lo_idx;

    // Descending scan leaves the lowest match; hi_* only considers indices >= ptr.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        any_c    = lo_found;
        idx_c    = hi_found ? hi_idx : lo_idx;
        onehot_c = '0;
        if (lo_found) onehot_c[idx_c] = 1'b1;
    end

endmodule

// File: rtl/permutation_arbiter.sv
// Round-robin arbiter sharing one Ascon permutation core between N_REQ requesters.
// Optional macro ARB_LOCK_EN lets a requester hold the core across permutations.
module permutation_arbiter
    import ascon_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W     = ASCON_W,
    parameter int unsigned RW    = ASCON_RW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*W-1:0]  req_state,
    input  logic [N_REQ*RW-1:0] req_rounds,
    input  logic [N_REQ-1:0]    lock,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [W-1:0]        rsp_state,
    output logic                busy,
    output logic [W-1:0]        perm_s,
    output logic [RW-1:0]       perm_rounds,
    output logic                perm_start,
    input  logic                perm_done,
    input  logic [W-1:0]        perm_out
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [W-1:0]      rsp_state_q, rsp_state_d;
    logic [W-1:0]      perm_s_q, perm_s_d;
    logic [RW-1:0]     perm_rounds_q, perm_rounds_d;
    logic              busy_q;
    logic              run_q;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              launch;
    logic              rel;
    logic [N_REQ-1:0]  launch_oh;
    logic [IW-1:0]     launch_sel;

    logic [W-1:0]      st_arr [N_REQ];
    logic [RW-1:0]     rd_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign st_arr[g] = req_state[g*W +: W];
        assign rd_arr[g] = req_rounds[g*RW +: RW];
    end

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .onehot_c (pick_onehot),
        .idx_c    (pick_idx),
        .any_c    (pick_any)
    );

`ifndef ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Next-state and registered-output values; launch/rel are shared entry/exit actions.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        win_d         = win_q;
        gnt_d         = gnt_q;
        rsp_valid_d   = '0;
        rsp_state_d   = rsp_state_q;
        perm_s_d      = perm_s_q;
        perm_rounds_d = perm_rounds_q;
        launch        = 1'b0;
        rel           = 1'b0;
        launch_oh     = pick_onehot;
        launch_sel    = pick_idx;

        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) launch = 1'b1;
            end
            RUN: begin
                if (perm_done) begin
                    rsp_state_d = perm_out;
                    rsp_valid_d = gnt_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
`ifdef ARB_LOCK_EN
                if (lock[win_q]) state_d = HOLD;
                else             rel     = 1'b1;
`else
                rel = 1'b1;
`endif
            end
`ifdef ARB_LOCK_EN
            HOLD: begin
                launch_oh  = gnt_q;
                launch_sel = win_q;
                if (req[win_q])        launch = 1'b1;
                else if (!lock[win_q]) rel    = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Zero rounds bypass the core and answer with the latched state.
        if (launch) begin
            win_d         = launch_sel;
            gnt_d         = launch_oh;
            perm_s_d      = st_arr[launch_sel];
            perm_rounds_d = rd_arr[launch_sel];
            if (rd_arr[launch_sel] == RW'(0)) begin
                state_d     = RESP;
                rsp_valid_d = launch_oh;
                rsp_state_d = st_arr[launch_sel];
            end else begin
                state_d = RUN;
            end
        end

        if (rel) begin
            gnt_d   = '0;
            state_d = IDLE;
            ptr_d   = (win_q == IW'(N_REQ - 1)) ? '0 : win_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            win_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_state_q   <= '0;
            perm_s_q      <= '0;
            perm_rounds_q <= '0;
            busy_q        <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            win_q         <= win_d;
            gnt_q         <= gnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_state_q   <= rsp_state_d;
            perm_s_q      <= perm_s_d;
            perm_rounds_q <= perm_rounds_d;
            busy_q        <= (state_d != IDLE);
            run_q         <= (state_d == RUN);
        end
    end

    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_state   = rsp_state_q;
    assign busy        = busy_q;
    assign perm_s      = perm_s_q;
    assign perm_rounds = perm_rounds_q;
    // Start drops in the same cycle the core reports done.
    assign perm_start  = run_q & ~perm_done;

endmodule

// File: tb/tb_permutation_arbiter.sv
// Directed bench for permutation_arbiter with a simple counting core model (out = ~in).
module tb_permutation_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 320;
    localparam int unsigned RW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, lock, gnt, rsp_valid;
    logic [N*W-1:0]  req_state;
    logic [N*RW-1:0] req_rounds;
    logic [W-1:0]    rsp_state, perm_s, perm_out;
    logic [RW-1:0]   perm_rounds;
    logic            busy, perm_start, perm_done, extra_done;
    int              cnt, core_lat;
    int              total, bad;
    int              n, starts;

    always #5 clk = ~clk;

    permutation_arbiter #(.N_REQ(N), .W(W), .RW(RW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_state   (req_state),
        .req_rounds  (req_rounds),
        .lock        (lock),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_state   (rsp_state),
        .busy        (busy),
        .perm_s      (perm_s),
        .perm_rounds (perm_rounds),
        .perm_start  (perm_start),
        .perm_done   (perm_done),
        .perm_out    (perm_out)
    );

    // Core model: done after core_lat cycles of start, result is bitwise inverse.
    assign perm_out  = ~perm_s;
    assign perm_done = (cnt == core_lat) | extra_done;

    always @(posedge clk or negedge rst) begin
        if (!rst)                cnt <= 0;
        else if (cnt == core_lat) cnt <= 0;
        else if (perm_start)     cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int budget, output int cyc, output int st);
        cyc = 0;
        st  = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (perm_start) st++;
        end while (rsp_valid == '0 && cyc < budget);
    endtask

    initial begin
        rst        = 1'b0;
        req        = '0;
        lock       = '0;
        req_state  = '0;
        req_rounds = '0;
        extra_done = 1'b0;
        core_lat   = 12;
        total      = 0;
        bad        = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",       W'(gnt),        W'(0));
        chk("rst_rsp_valid", W'(rsp_valid),  W'(0));
        chk("rst_busy",      W'(busy),       W'(0));
        chk("rst_start",     W'(perm_start), W'(0));
        chk("rst_perm_s",    perm_s,         W'(0));
        chk("rst_rsp_state", rsp_state,      W'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two persistent requesters alternate, one idle cycle between grants.
        core_lat = 3;
        req_state[0 +: W]   = W'(320'h10);
        req_state[W +: W]   = W'(320'h20);
        req_rounds[0 +: RW] = RW'(12);
        req_rounds[RW +: RW] = RW'(12);
        req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            logic [N-1:0] e;
            e = (g % 2 == 0) ? 2'b01 : 2'b10;
            wait_rsp(40, n, starts);
            chk("rr_gnt",   W'(gnt),       W'(e));
            chk("rr_valid", W'(rsp_valid), W'(e));
            chk("rr_state", rsp_state, (g % 2 == 0) ? ~W'(320'h10) : ~W'(320'h20));
            if (g == 3) req = '0;
            @(posedge clk);
            #1;
            chk("rr_idle_busy", W'(busy), W'(0));
            chk("rr_idle_gnt",  W'(gnt),  W'(0));
        end

        // Single 12-round permutation from requester 0.
        core_lat = 12;
        req_state[0 +: W] = W'(320'h1);
        req = 2'b01;
        wait_rsp(40, n, starts);
        chk("p12_latency", W'(n),         W'(14));
        chk("p12_starts",  W'(starts),    W'(12));
        chk("p12_valid",   W'(rsp_valid), W'(2'b01));
        chk("p12_state",   rsp_state,     ~W'(320'h1));
        req = '0;
        @(posedge clk);
        #1;
        chk("p12_pulse_once", W'(rsp_valid), W'(0));
        chk("p12_idle",       W'(busy),      W'(0));

        // Zero rounds bypass the core.
        req_state[W +: W]    = W'(320'hABCD);
        req_rounds[RW +: RW] = RW'(0);
        req = 2'b10;
        wait_rsp(10, n, starts);
        chk("byp_latency", W'(n),         W'(1));
        chk("byp_starts",  W'(starts),    W'(0));
        chk("byp_valid",   W'(rsp_valid), W'(2'b10));
        chk("byp_state",   rsp_state,     W'(320'hABCD));
        req = '0;
        @(posedge clk);
        #1;

        // Done while idle is ignored.
        extra_done = 1'b1;
        @(posedge clk);
        #1;
        extra_done = 1'b0;
        chk("idle_done_busy",  W'(busy),      W'(0));
        chk("idle_done_valid", W'(rsp_valid), W'(0));

        // Winner drops req mid-run; response still pulses and pointer advances.
        req_state[0 +: W] = W'(320'h5);
        req = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        req = '0;
        wait_rsp(40, n, starts);
        chk("drop_valid", W'(rsp_valid), W'(2'b01));
        chk("drop_state", rsp_state,     ~W'(320'h5));
        @(posedge clk);
        #1;
        chk("drop_pulse_once", W'(rsp_valid), W'(0));
        req = 2'b11;
        wait_rsp(40, n, starts);
        chk("drop_next_gnt",   W'(gnt),       W'(2'b10));
        chk("drop_next_valid", W'(rsp_valid), W'(2'b10));
        req = '0;
        @(posedge clk);
        #1;

        // Reset in the middle of a run aborts at once.
        req = 2'b01;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_start", W'(perm_start), W'(1));
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt",   W'(gnt),        W'(0));
        chk("mid_rst_start", W'(perm_start), W'(0));
        chk("mid_rst_busy",  W'(busy),       W'(0));
        chk("mid_rst_valid", W'(rsp_valid),  W'(0));
        req = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 2'b01;
        wait_rsp(40, n, starts);
        chk("post_rst_latency", W'(n),         W'(14));
        chk("post_rst_valid",   W'(rsp_valid), W'(2'b01));
        chk("post_rst_state",   rsp_state,     ~W'(320'h5));
        req = '0;
        @(posedge clk);
        #1;

`ifdef ARB_LOCK_EN
        // Requester 0 holds the core for three permutations, then releases.
        core_lat = 3;
        lock = 2'b01;
        req  = 2'b01;
        for (int k = 0; k < 3; k++) begin
            wait_rsp(40, n, starts);
            chk("lock_gnt",   W'(gnt),       W'(2'b01));
            chk("lock_valid", W'(rsp_valid), W'(2'b01));
            if (k == 0) req = 2'b11;
            if (k < 2) begin
                @(posedge clk);
                #1;
                chk("lock_hold_gnt", W'(gnt), W'(2'b01));
            end else begin
                lock = '0;
                req  = 2'b10;
            end
        end
        wait_rsp(40, n, starts);
        chk("unlock_gnt", W'(gnt), W'(2'b10));
        req = '0;
        @(posedge clk);
        #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
